// File: rtl/scalar_mul_ctrl_pkg.sv
// scalar_mul_ctrl_pkg: shared width default and sequencer state encoding.
package scalar_mul_ctrl_pkg;
  localparam int MAX_BITS = 256;
  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_NEXT, S_DBL_REQ, S_DBL_WAIT, S_ADD_REQ, S_ADD_WAIT, S_DONE
  } state_t;
endpackage

// File: rtl/scalar_mul_ctrl.sv
// scalar_mul_ctrl: double-and-add-always sequencer driving external doubler/adder handshakes.
module scalar_mul_ctrl
  import scalar_mul_ctrl_pkg::*;
#(
  parameter int WIDTH = MAX_BITS,
  parameter int IDXW  = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_k,
  input  logic [WIDTH-1:0] i_px,
  input  logic [WIDTH-1:0] i_py,
  output logic             o_busy,
  output logic             o_finished,
  output logic [WIDTH-1:0] o_result_x,
  output logic [WIDTH-1:0] o_result_y,
  output logic             o_dbl_start,
  output logic [WIDTH-1:0] o_dbl_x,
  output logic [WIDTH-1:0] o_dbl_y,
  input  logic             i_dbl_finish,
  input  logic [WIDTH-1:0] i_dbl_x,
  input  logic [WIDTH-1:0] i_dbl_y,
  output logic             o_add_start,
  output logic [WIDTH-1:0] o_add_x1,
  output logic [WIDTH-1:0] o_add_y1,
  output logic [WIDTH-1:0] o_add_x2,
  output logic [WIDTH-1:0] o_add_y2,
  output logic             o_add_bit,
  input  logic             i_add_finish,
  input  logic [WIDTH-1:0] i_add_x,
  input  logic [WIDTH-1:0] i_add_y
);
  localparam logic [WIDTH-1:0] INF = '1;
  state_t            state;
  logic [WIDTH-1:0]  k, px, py, qx, qy;
  logic [IDXW-1:0]   idx;
  assign o_dbl_x   = qx;
  assign o_dbl_y   = qy;
  assign o_add_x1  = qx;
  assign o_add_y1  = qy;
  assign o_add_x2  = px;
  assign o_add_y2  = py;
  assign o_add_bit = k[idx];
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= S_IDLE;
      k           <= '0;
      px          <= '0;
      py          <= '0;
      qx          <= '0;
      qy          <= '0;
      idx         <= '0;
      o_busy      <= 1'b0;
      o_finished  <= 1'b0;
      o_result_x  <= '0;
      o_result_y  <= '0;
      o_dbl_start <= 1'b0;
      o_add_start <= 1'b0;
    end else begin
      o_dbl_start <= 1'b0;
      o_add_start <= 1'b0;
      o_finished  <= 1'b0;
      case (state)
        S_IDLE: if (i_start) begin
          k      <= i_k;
          px     <= i_px;
          py     <= i_py;
          qx     <= i_px;
          qy     <= i_py;
          idx    <= IDXW'(WIDTH - 1);
          o_busy <= 1'b1;
          state  <= S_SCAN;
        end
        S_SCAN: begin
          if (k[idx]) state <= S_NEXT;
          else if (idx == '0) begin
            qx    <= INF;
            qy    <= INF;
            state <= S_DONE;
          end else idx <= idx - 1'b1;
        end
        S_NEXT: begin
          if (idx == '0) state <= S_DONE;
          else begin
            idx   <= idx - 1'b1;
            state <= S_DBL_REQ;
          end
        end
        S_DBL_REQ: begin
          o_dbl_start <= 1'b1;
          state       <= S_DBL_WAIT;
        end
        // A doubled point at infinity skips the adder: inf + P = P, inf + 0 = inf.
        S_DBL_WAIT: if (i_dbl_finish) begin
          if (&i_dbl_x) begin
            qx    <= k[idx] ? px : INF;
            qy    <= k[idx] ? py : INF;
            state <= S_NEXT;
          end else begin
            qx    <= i_dbl_x;
            qy    <= i_dbl_y;
            state <= S_ADD_REQ;
          end
        end
        S_ADD_REQ: begin
          o_add_start <= 1'b1;
          state       <= S_ADD_WAIT;
        end
        S_ADD_WAIT: if (i_add_finish) begin
          qx    <= i_add_x;
          qy    <= i_add_y;
          state <= S_NEXT;
        end
        S_DONE: begin
          o_finished <= 1'b1;
          o_busy     <= 1'b0;
          o_result_x <= qx;
          o_result_y <= qy;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
